// File: rtl/aes_pkg.sv
// Shared definitions for the AES decrypt scheduler slice.
// Contents:
//   AES_BLK_W      - AES block width (128 bits).
//   sched_state_e  - scheduler flush FSM states (RUN, DRAIN, DONE, HOLD).
//   rr_pick        - two-way round-robin grant helper (0 = req0, 1 = req1).
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_e;

  // With both requesters valid the one not served last wins; otherwise the
  // single valid requester wins. With neither valid the result is unused.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
    logic pick;
    if (v0 && v1) begin
      pick = ~last_grant;
    end else if (v1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/aes_tag_fifo.sv
// Tag FIFO remembering which requester owns each block in the pipeline.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears contents).
//   push        - write push_data at the tail.
//   push_data   - tag to store (WIDTH bits).
//   pop         - discard the head entry.
//   pop_data    - current head entry (valid while count != 0).
//   count       - number of stored entries, 0..DEPTH.
// Push while full is accepted only together with a pop; pop while empty is
// ignored, so the count can never wrap.
module aes_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; the pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/aes_decrypt_scheduler.sv
// Two-requester scheduler in front of an AES decrypt pipeline.
// Accepts ciphertext blocks from req0/req1 (round-robin), issues them to the
// pipeline one cycle after the handshake, tags each issue with its requester
// and routes pipeline results back in issue order. A flush request stops
// issuing, drains the pipeline and pulses flush_done.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset.
//   reqN_valid/reqN_data/reqN_ready - requester block input handshakes.
//   pipe_data, pipe_valid         - registered issue to the pipeline.
//   pipe_res_data, pipe_res_valid - pipeline results (no backpressure).
//   rspN_valid, rsp_data          - registered plaintext return strobes.
//   flush_req, flush_done         - drain request (level) / completion pulse.
//   inflight                      - blocks currently in the pipeline.
//   err_unexp                     - sticky: result with nothing outstanding.
// Optional build macro AES_SCHED_STATS_EN adds saturating counters
// issued0/issued1/retired0/retired1 [CNT_W-1:0].
module aes_decrypt_scheduler
  import aes_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req0_valid,
  input  logic [0:AES_BLK_W-1]          req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [0:AES_BLK_W-1]          req1_data,
  output logic                          req1_ready,
  output logic [0:AES_BLK_W-1]          pipe_data,
  output logic                          pipe_valid,
  input  logic [0:AES_BLK_W-1]          pipe_res_data,
  input  logic                          pipe_res_valid,
  output logic                          rsp0_valid,
  output logic                          rsp1_valid,
  output logic [0:AES_BLK_W-1]          rsp_data,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
`ifdef AES_SCHED_STATS_EN
  output logic [CNT_W-1:0]              issued0,
  output logic [CNT_W-1:0]              issued1,
  output logic [CNT_W-1:0]              retired0,
  output logic [CNT_W-1:0]              retired1,
`endif
  output logic                          err_unexp
);

  localparam int IF_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [IF_W-1:0] FULL_CNT = IF_W'(MAX_INFLIGHT);

  sched_state_e         state_r;
  logic                 last_grant_r;
  logic                 pipe_valid_r;
  logic [0:AES_BLK_W-1] pipe_data_r;
  logic                 rsp0_valid_r;
  logic                 rsp1_valid_r;
  logic [0:AES_BLK_W-1] rsp_data_r;
  logic                 flush_done_r;
  logic                 err_unexp_r;

  logic                 grant_s;
  logic                 can_issue_s;
  logic                 req0_ready_s;
  logic                 req1_ready_s;
  logic                 issue_s;
  logic [0:AES_BLK_W-1] issue_data_s;
  logic                 resp_ok_s;
  logic                 tag_head_s;
  logic [IF_W-1:0]      count_s;

  // Grant and ready: issue only in RUN, below the in-flight limit, and never
  // in the cycle flush_req is first seen. Ready goes only to the granted side.
  always_comb begin
    grant_s      = rr_pick(req0_valid, req1_valid, last_grant_r);
    can_issue_s  = 1'b0;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if ((state_r == ST_RUN) && !flush_req && (count_s < FULL_CNT)) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
    if (can_issue_s) begin
      req0_ready_s = req0_valid && !grant_s;
      req1_ready_s = req1_valid && grant_s;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
  end

  assign issue_s      = (req0_valid && req0_ready_s) || (req1_valid && req1_ready_s);
  assign issue_data_s = grant_s ? req1_data : req0_data;
  // A result with nothing outstanding is dropped (and flagged) rather than popped.
  assign resp_ok_s    = pipe_res_valid && (count_s != {IF_W{1'b0}});

  aes_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue_s),
    .push_data (grant_s),
    .pop       (resp_ok_s),
    .pop_data  (tag_head_s),
    .count     (count_s)
  );

  // Issue register, round-robin history, response routing and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      pipe_valid_r <= 1'b0;
      pipe_data_r  <= {AES_BLK_W{1'b0}};
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp_data_r   <= {AES_BLK_W{1'b0}};
      err_unexp_r  <= 1'b0;
    end else begin
      pipe_valid_r <= issue_s;
      if (issue_s) begin
        pipe_data_r  <= issue_data_s;
        last_grant_r <= grant_s;
      end
      rsp0_valid_r <= resp_ok_s && !tag_head_s;
      rsp1_valid_r <= resp_ok_s && tag_head_s;
      if (resp_ok_s) begin
        rsp_data_r <= pipe_res_data;
      end
      if (pipe_res_valid && !resp_ok_s) begin
        err_unexp_r <= 1'b1;
      end
    end
  end

  // Flush FSM; flush_done is raised on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      flush_done_r <= 1'b0;
    end else begin
      flush_done_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (flush_req) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_s == {IF_W{1'b0}}) begin
            state_r      <= ST_DONE;
            flush_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= flush_req ? ST_HOLD : ST_RUN;
        end
        ST_HOLD: begin
          if (!flush_req) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

`ifdef AES_SCHED_STATS_EN
  logic [CNT_W-1:0] issued0_r;
  logic [CNT_W-1:0] issued1_r;
  logic [CNT_W-1:0] retired0_r;
  logic [CNT_W-1:0] retired1_r;
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  // Saturating per-requester issue/retire counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued0_r  <= {CNT_W{1'b0}};
      issued1_r  <= {CNT_W{1'b0}};
      retired0_r <= {CNT_W{1'b0}};
      retired1_r <= {CNT_W{1'b0}};
    end else begin
      if (issue_s && !grant_s && (issued0_r != STAT_MAX)) begin
        issued0_r <= issued0_r + STAT_ONE;
      end
      if (issue_s && grant_s && (issued1_r != STAT_MAX)) begin
        issued1_r <= issued1_r + STAT_ONE;
      end
      if (resp_ok_s && !tag_head_s && (retired0_r != STAT_MAX)) begin
        retired0_r <= retired0_r + STAT_ONE;
      end
      if (resp_ok_s && tag_head_s && (retired1_r != STAT_MAX)) begin
        retired1_r <= retired1_r + STAT_ONE;
      end
    end
  end

  assign issued0  = issued0_r;
  assign issued1  = issued1_r;
  assign retired0 = retired0_r;
  assign retired1 = retired1_r;
`endif

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign pipe_valid = pipe_valid_r;
  assign pipe_data  = pipe_data_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp_data   = rsp_data_r;
  assign flush_done = flush_done_r;
  assign inflight   = count_s;
  assign err_unexp  = err_unexp_r;

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// Self-checking bench for aes_decrypt_scheduler (MAX_INFLIGHT = 8).
// Reference model: a queue of outstanding requester IDs in issue order, the
// last-served requester, a sticky error flag and the flush phase; every cycle
// the bench predicts ready, issue, routing and counts from those.
module tb_aes_decrypt_scheduler;

  localparam int MAX = 8;

  logic         clk;
  logic         rst_n;
  logic         req0_valid;
  logic [0:127] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [0:127] req1_data;
  logic         req1_ready;
  logic [0:127] pipe_data;
  logic         pipe_valid;
  logic [0:127] pipe_res_data;
  logic         pipe_res_valid;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [0:127] rsp_data;
  logic         flush_req;
  logic         flush_done;
  logic [3:0]   inflight;
  logic         err_unexp;
`ifdef AES_SCHED_STATS_EN
  logic [15:0]  issued0, issued1, retired0, retired1;
`endif

  aes_decrypt_scheduler #(.MAX_INFLIGHT(MAX), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .pipe_data      (pipe_data),
    .pipe_valid     (pipe_valid),
    .pipe_res_data  (pipe_res_data),
    .pipe_res_valid (pipe_res_valid),
    .rsp0_valid     (rsp0_valid),
    .rsp1_valid     (rsp1_valid),
    .rsp_data       (rsp_data),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .inflight       (inflight),
`ifdef AES_SCHED_STATS_EN
    .issued0        (issued0),
    .issued1        (issued1),
    .retired0       (retired0),
    .retired1       (retired1),
`endif
    .err_unexp      (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic         m_q[$];       // requester IDs in issue order
  logic         m_last;       // last requester granted
  logic         m_err;
  logic [0:127] m_pdata;      // last issued block
  logic [0:127] m_rsp;
  int           m_phase;      // 0 issuing, 1 draining, 2 done pulse, 3 holding

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = 1'b1;
    m_err   = 1'b0;
    m_pdata = '0;
    m_rsp   = '0;
    m_phase = 0;
  endtask

  task automatic set_idle();
    req0_valid     = 1'b0;
    req1_valid     = 1'b0;
    pipe_res_valid = 1'b0;
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check combinational readies at the negedge, predict the
  // registered results, then check them just after the rising edge.
  task automatic tick();
    logic g, can, e_r0, e_r1, hs, tag, e_v0, e_v1, e_fd;
    int   sz;
    @(negedge clk);
    sz  = m_q.size();
    can = (m_phase == 0) && !flush_req && (sz < MAX);
    if (req0_valid && req1_valid) g = ~m_last;
    else                          g = req1_valid;
    e_r0 = can && req0_valid && !g;
    e_r1 = can && req1_valid && g;
    chk("req0_ready", {127'd0, req0_ready}, {127'd0, e_r0});
    chk("req1_ready", {127'd0, req1_ready}, {127'd0, e_r1});
    hs   = e_r0 || e_r1;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (pipe_res_valid) begin
      if (sz == 0) begin
        m_err = 1'b1;
      end else begin
        tag   = m_q.pop_front();
        e_v0  = !tag;
        e_v1  = tag;
        m_rsp = pipe_res_data;
      end
    end
    e_fd = (m_phase == 1) && (sz == 0);
    case (m_phase)
      0: if (flush_req) m_phase = 1;
      1: if (sz == 0) m_phase = 2;
      2: m_phase = flush_req ? 3 : 0;
      3: if (!flush_req) m_phase = 0;
      default: m_phase = 0;
    endcase
    if (hs) begin
      m_q.push_back(g);
      m_last  = g;
      m_pdata = g ? req1_data : req0_data;
    end
    @(posedge clk);
    #1;
    chk("pipe_valid", {127'd0, pipe_valid}, {127'd0, hs});
    chk("pipe_data", pipe_data, m_pdata);
    chk("rsp0_valid", {127'd0, rsp0_valid}, {127'd0, e_v0});
    chk("rsp1_valid", {127'd0, rsp1_valid}, {127'd0, e_v1});
    if (e_v0 || e_v1) chk("rsp_data", rsp_data, m_rsp);
    chk("flush_done", {127'd0, flush_done}, {127'd0, e_fd});
    chk("err_unexp", {127'd0, err_unexp}, {127'd0, m_err});
    chk("inflight", {124'd0, inflight}, 128'(m_q.size()));
  endtask

  task automatic respond(input logic [0:127] d);
    pipe_res_valid = 1'b1;
    pipe_res_data  = d;
    tick();
    pipe_res_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_q.size() > 0; i++) respond(rnd128());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pipe_valid"}, {127'd0, pipe_valid}, 128'd0);
    chk({tag, "_pipe_data"}, pipe_data, 128'd0);
    chk({tag, "_rsp0"}, {127'd0, rsp0_valid}, 128'd0);
    chk({tag, "_rsp1"}, {127'd0, rsp1_valid}, 128'd0);
    chk({tag, "_rsp_data"}, rsp_data, 128'd0);
    chk({tag, "_flush_done"}, {127'd0, flush_done}, 128'd0);
    chk({tag, "_err"}, {127'd0, err_unexp}, 128'd0);
    chk({tag, "_inflight"}, {124'd0, inflight}, 128'd0);
  endtask

  initial begin
    logic [0:127] d0;
    rst_n = 1'b0;
    set_idle();
    req0_data = '0; req1_data = '0; pipe_res_data = '0; flush_req = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // contention: both valid for 4 cycles -> grants 0,1,0,1
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_data = rnd128();
      req1_data = rnd128();
      tick();
    end
    set_idle();
    chk("contention_inflight", {124'd0, inflight}, 128'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      respond(rnd128());
    end

    // single requester: fixed ciphertext, result 9 cycles later
    req0_valid = 1'b1;
    req0_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    tick();
    req0_valid = 1'b0;
    chk("single_pipe_data", pipe_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    repeat (8) tick();
    respond(128'h00112233445566778899aabbccddeeff);
    chk("single_rsp_data", rsp_data, 128'h00112233445566778899aabbccddeeff);
    chk("single_rsp0", {127'd0, rsp0_valid}, 128'd1);
    tick();

    // back-pressure: 8 issues, then ready low until one response
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_data = rnd128();
      tick();
    end
    chk("bp_inflight", {124'd0, inflight}, 128'd8);
    respond(rnd128());
    req0_data = rnd128();
    tick();
    req0_valid = 1'b0;
    drain();

    // flush with 3 in flight, held through DONE into HOLD
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_data = rnd128();
      tick();
    end
    flush_req = 1'b1;
    req0_valid = 1'b1;
    req0_data = rnd128();
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      respond(rnd128());
      tick();
    end
    repeat (3) tick();
    flush_req = 1'b0;
    repeat (3) tick();
    set_idle();
    drain();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      req0_valid     = ($urandom_range(0, 1) == 1);
      req1_valid     = ($urandom_range(0, 1) == 1);
      req0_data      = rnd128();
      req1_data      = rnd128();
      pipe_res_data  = rnd128();
      pipe_res_valid = (m_q.size() > 0) && ($urandom_range(0, 9) < 4);
      tick();
    end
    set_idle();
    drain();

    // unexpected response with nothing outstanding
    respond(rnd128());
    chk("err_set", {127'd0, err_unexp}, 128'd1);
    tick();

    // reset mid-stream, then late responses flag err_unexp
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_data = rnd128();
      tick();
    end
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = rnd128();
    respond(d0);
    respond(d0);
    chk("late_err", {127'd0, err_unexp}, 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
